// File: rtl/knn_pkg.sv
// Shared kNN types: coordinate width, BDU dimension codes, point/tag types,
// streamer states and the bit picker used by point_shreg.
package knn_pkg;

    localparam int B    = 32;
    localparam int ID_W = 16;
    localparam int BW   = $clog2(B + 1);

    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_X    = 2'b01;
    localparam logic [1:0] CODE_Y    = 2'b10;
    localparam logic [1:0] CODE_Z    = 2'b11;

    typedef struct packed {
        logic [B-1:0] x;
        logic [B-1:0] y;
        logic [B-1:0] z;
    } point_t;

    typedef logic [ID_W-1:0] ref_tag_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READY,
        S_STREAM,
        S_DRAIN
    } state_t;

    // Bit [B-b] of the dimension selected by code; b = 1 is the MSB.
    // b = 0 shifts everything out and yields 0.
    function automatic logic pick_bit(point_t p, logic [BW-1:0] b,
                                      logic [1:0] code);
        logic [B-1:0] w;
        logic [B-1:0] s;
        case (code)
            CODE_X:  w = p.x;
            CODE_Y:  w = p.y;
            CODE_Z:  w = p.z;
            default: w = '0;
        endcase
        s = w >> (B - int'(b));
        return s[0];
    endfunction

endpackage

// File: rtl/point_shreg.sv
// Holds one point and returns the bit addressed by b/code.
// Ports: clk, rst_n, ld/d (load), b/code (address), sel_bit (addressed bit).
module point_shreg
    import knn_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld,
    input  point_t        d,
    input  logic [BW-1:0] b,
    input  logic [1:0]    code,
    output logic          sel_bit
);

    point_t pt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pt <= '0;
        end else if (ld) begin
            pt <= d;
        end
    end

    // Looks ahead to the point being loaded so the caller can register
    // the first bit of a fresh point on the same edge that loads it.
    assign sel_bit = pick_bit(ld ? d : pt, b, code);

endmodule

// File: rtl/bdu_bit_streamer.sv
// Serializes query/reference points MSB first, x,y,z interleaved, into one
// BDU lane and retires each reference on terminate/done.
// Ports: clk, rst_n; q_load/q_ready/q_x..z (query); ref_valid/ref_ready/
// ref_x..z/ref_id (reference); bdu_terminate/bdu_done (BDU verdict);
// valid/q_bit/r_bit/code/b (BDU inputs); retire/retire_kept/retire_id.
// Option: BDU_STREAM_PREFETCH_EN adds a one-entry prefetch buffer.
module bdu_bit_streamer #(
    parameter int B    = knn_pkg::B,
    parameter int ID_W = knn_pkg::ID_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   q_load,
    output logic                   q_ready,
    input  logic [B-1:0]           q_x,
    input  logic [B-1:0]           q_y,
    input  logic [B-1:0]           q_z,
    input  logic                   ref_valid,
    output logic                   ref_ready,
    input  logic [B-1:0]           ref_x,
    input  logic [B-1:0]           ref_y,
    input  logic [B-1:0]           ref_z,
    input  logic [ID_W-1:0]        ref_id,
    input  logic                   bdu_terminate,
    input  logic                   bdu_done,
    output logic                   valid,
    output logic                   q_bit,
    output logic                   r_bit,
    output logic [1:0]             code,
    output logic [$clog2(B+1)-1:0] b,
    output logic                   retire,
    output logic                   retire_kept,
    output logic [ID_W-1:0]        retire_id
);
    import knn_pkg::*;

    localparam int NB = $clog2(B + 1);

    state_t          state;
    point_t          q_in;
    point_t          r_in;
    logic            hs;
    logic            q_acc;
    logic            last;
    logic            leave;
    logic            start;
    logic [NB-1:0]   nb;
    logic [1:0]      ncode;
    logic            q_nbit;
    logic            r_nbit;
    logic [ID_W-1:0] cur_id;

    assign q_in  = {q_x, q_y, q_z};
    assign r_in  = {ref_x, ref_y, ref_z};
    assign hs    = ref_valid && ref_ready;
    assign q_acc = q_load && q_ready;
    assign last  = (b == NB'(B)) && (code == CODE_Z);
    assign leave = (state == S_STREAM && bdu_terminate) ||
                   (state == S_DRAIN && (bdu_done || bdu_terminate));

    // Address of the bit registered at the next edge.
    always_comb begin
        nb    = b;
        ncode = code;
        if (start) begin
            nb    = NB'(1);
            ncode = CODE_X;
        end else if (code == CODE_Z) begin
            nb    = b + NB'(1);
            ncode = CODE_X;
        end else begin
            ncode = code + 2'd1;
        end
    end

    point_shreg u_query (
        .clk     (clk),
        .rst_n   (rst_n),
        .ld      (q_acc),
        .d       (q_in),
        .b       (nb),
        .code    (ncode),
        .sel_bit (q_nbit)
    );

`ifdef BDU_STREAM_PREFETCH_EN
    // Two ref slots used ping-pong: one active, the other is the
    // prefetch buffer. A start on exit simply flips the active slot.
    logic            act;
    logic            na;
    logic            tgt;
    logic            pf_full;
    logic            pf_fill;
    logic            ld0;
    logic            ld1;
    logic            sel0;
    logic            sel1;
    logic [ID_W-1:0] id0;
    logic [ID_W-1:0] id1;

    assign ref_ready = !pf_full && (state != S_IDLE);
    assign q_ready   = !pf_full &&
                       (state == S_IDLE || state == S_READY);
    assign start     = (state == S_READY && hs) ||
                       (leave && (pf_full || hs));
    assign pf_fill   = hs && !leave &&
                       (state == S_STREAM || state == S_DRAIN);
    assign tgt       = (state == S_READY) ? act : !act;
    assign ld0       = hs && !tgt;
    assign ld1       = hs && tgt;
    assign na        = (leave && start) ? !act : act;
    assign cur_id    = act ? id1 : id0;
    assign r_nbit    = na ? sel1 : sel0;

    point_shreg u_ref0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .ld      (ld0),
        .d       (r_in),
        .b       (nb),
        .code    (ncode),
        .sel_bit (sel0)
    );

    point_shreg u_ref1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .ld      (ld1),
        .d       (r_in),
        .b       (nb),
        .code    (ncode),
        .sel_bit (sel1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act     <= 1'b0;
            pf_full <= 1'b0;
            id0     <= '0;
            id1     <= '0;
        end else begin
            act <= na;
            if (ld0) id0 <= ref_id;
            if (ld1) id1 <= ref_id;
            if (leave && pf_full) begin
                pf_full <= 1'b0;
            end else if (pf_fill) begin
                pf_full <= 1'b1;
            end
        end
    end
`else
    logic [ID_W-1:0] act_id;

    assign ref_ready = (state == S_READY);
    assign q_ready   = (state == S_IDLE || state == S_READY);
    assign start     = (state == S_READY) && hs;
    assign cur_id    = act_id;

    point_shreg u_ref (
        .clk     (clk),
        .rst_n   (rst_n),
        .ld      (start),
        .d       (r_in),
        .b       (nb),
        .code    (ncode),
        .sel_bit (r_nbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_id <= '0;
        end else if (start) begin
            act_id <= ref_id;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            valid       <= 1'b0;
            q_bit       <= 1'b0;
            r_bit       <= 1'b0;
            code        <= CODE_NONE;
            b           <= '0;
            retire      <= 1'b0;
            retire_kept <= 1'b0;
            retire_id   <= '0;
        end else begin
            retire      <= leave;
            retire_kept <= leave && !bdu_terminate;
            if (leave) retire_id <= cur_id;
            if (start) begin
                state <= S_STREAM;
                valid <= 1'b1;
                b     <= nb;
                code  <= ncode;
                q_bit <= q_nbit;
                r_bit <= r_nbit;
            end else if (leave) begin
                state <= S_READY;
                valid <= 1'b0;
                b     <= '0;
                code  <= CODE_NONE;
                q_bit <= 1'b0;
                r_bit <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (q_acc) state <= S_READY;
                    end
                    S_STREAM: begin
                        if (last) begin
                            state <= S_DRAIN;
                            valid <= 1'b0;
                            b     <= '0;
                            code  <= CODE_NONE;
                            q_bit <= 1'b0;
                            r_bit <= 1'b0;
                        end else begin
                            b     <= nb;
                            code  <= ncode;
                            q_bit <= q_nbit;
                            r_bit <= r_nbit;
                        end
                    end
                    S_READY: ;
                    S_DRAIN: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bdu_bit_streamer.sv
// Bench for bdu_bit_streamer: point-level model with a linear bit counter,
// a reactive BDU model, per-cycle compare and directed literal checks.
module tb_bdu_bit_streamer;

    localparam int B    = 32;
    localparam int ID_W = 16;
    localparam int BW   = $clog2(B + 1);
`ifdef BDU_STREAM_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    logic            clk = 0;
    logic            rst_n;
    logic            q_load;
    logic            q_ready;
    logic [B-1:0]    q_x, q_y, q_z;
    logic            ref_valid;
    logic            ref_ready;
    logic [B-1:0]    ref_x, ref_y, ref_z;
    logic [ID_W-1:0] ref_id;
    logic            bdu_terminate;
    logic            bdu_done;
    logic            valid, q_bit, r_bit;
    logic [1:0]      code;
    logic [BW-1:0]   b;
    logic            retire, retire_kept;
    logic [ID_W-1:0] retire_id;

    bdu_bit_streamer #(.B(B), .ID_W(ID_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .q_load(q_load), .q_ready(q_ready),
        .q_x(q_x), .q_y(q_y), .q_z(q_z),
        .ref_valid(ref_valid), .ref_ready(ref_ready),
        .ref_x(ref_x), .ref_y(ref_y), .ref_z(ref_z), .ref_id(ref_id),
        .bdu_terminate(bdu_terminate), .bdu_done(bdu_done),
        .valid(valid), .q_bit(q_bit), .r_bit(r_bit),
        .code(code), .b(b),
        .retire(retire), .retire_kept(retire_kept), .retire_id(retire_id)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Point-level model: mk counts bits sent (0..3B-1 streaming, 3B drain).
    logic [B-1:0]    mq [3];
    logic [B-1:0]    mr [3];
    logic [B-1:0]    mp [3];
    bit              mhaveq, mact, mpf, m_ret, m_kept;
    int              mk;
    logic [ID_W-1:0] mid, mpid, m_rid;
    bit              s_strm, s_drn, s_ex, s_hs, s_qa, s_rr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mhaveq = 0; mact = 0; mpf = 0; mk = 0;
            m_ret = 0; m_kept = 0; m_rid = 0;
        end else begin
            s_strm = mact && mk < 3 * B;
            s_drn  = mact && mk == 3 * B;
            s_rr   = PF ? (mhaveq && !mpf) : (mhaveq && !mact);
            s_hs   = ref_valid && s_rr;
            s_qa   = q_load && !mact && !mpf;
            s_ex   = (s_strm && bdu_terminate) ||
                     (s_drn && (bdu_done || bdu_terminate));
            m_ret  = s_ex;
            m_kept = s_ex && !bdu_terminate;
            if (s_ex) begin
                m_rid = mid;
                mact  = 0;
            end else if (s_strm) begin
                mk++;
            end
            if (!mact) begin
                if (mpf) begin
                    mr = mp; mid = mpid; mact = 1; mk = 0; mpf = 0;
                end else if (s_hs) begin
                    mr[0] = ref_x; mr[1] = ref_y; mr[2] = ref_z;
                    mid = ref_id; mact = 1; mk = 0;
                end
            end else if (s_hs) begin
                mp[0] = ref_x; mp[1] = ref_y; mp[2] = ref_z;
                mpid = ref_id; mpf = 1;
            end
            if (s_qa) begin
                mq[0] = q_x; mq[1] = q_y; mq[2] = q_z; mhaveq = 1;
            end
        end
    end

    // Reactive BDU model.
    bit              thr0 = 0, both_mode = 0;
    int              term_k = -1;
    logic [ID_W-1:0] term_id = 0;

    always @(posedge clk) begin
        #2;
        bdu_done      = mact && mk == 3 * B;
        bdu_terminate = mact && ((thr0 && mk < 3 * B) ||
                        (term_k >= 0 && mk == term_k && mid == term_id) ||
                        (both_mode && mk == 3 * B));
    end

    int  e_dim, e_bi;
    bit  e_valid;
    always @(negedge clk) begin
        if (chk_en) begin
            e_valid = mact && mk < 3 * B;
            chk("valid", valid, e_valid);
            if (e_valid) begin
                e_dim = mk % 3;
                e_bi  = B - 1 - mk / 3;
                chk("code", code, e_dim + 1);
                chk("b", b, mk / 3 + 1);
                chk("q_bit", q_bit, mq[e_dim][e_bi]);
                chk("r_bit", r_bit, mr[e_dim][e_bi]);
            end else begin
                chk("code_idle", code, 0);
            end
            chk("retire", retire, m_ret);
            if (m_ret) begin
                chk("retire_kept", retire_kept, m_kept);
                chk("retire_id", retire_id, m_rid);
            end
            chk("q_ready", q_ready, !mact && !mpf);
            chk("ref_ready", ref_ready,
                PF ? (mhaveq && !mpf) : (mhaveq && !mact));
        end
    end

    bit cnt_en = 0;
    int nbits = 0, nret = 0, nkept = 0;
    always @(negedge clk) begin
        if (cnt_en) begin
            if (valid) nbits++;
            if (retire) begin
                nret++;
                if (retire_kept) nkept++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_q(input logic [B-1:0] x, y, z);
        bit ok;
        ok = 0;
        q_x = x; q_y = y; q_z = z; q_load = 1;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (q_ready) begin
                ok = 1;
                @(posedge clk);
                #1;
            end
        end
        q_load = 0;
        chk("q_accept", ok, 1);
    endtask

    task automatic push_ref(input logic [B-1:0] x, y, z,
                            input logic [ID_W-1:0] id);
        bit ok;
        ok = 0;
        ref_x = x; ref_y = y; ref_z = z; ref_id = id; ref_valid = 1;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (ref_ready) begin
                ok = 1;
                @(posedge clk);
                #1;
            end
        end
        ref_valid = 0;
        chk("ref_accept", ok, 1);
    endtask

    task automatic wait_retire(input bit kept, input logic [ID_W-1:0] id);
        bit seen;
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (retire) begin
                seen = 1;
                chk("lit_kept", retire_kept, kept);
                chk("lit_id", retire_id, id);
            end
        end
        chk("retire_seen", seen, 1);
        tick(1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    int t_term, f1, f2;
    bit found;

    initial begin
        rst_n = 0; q_load = 0; q_x = 0; q_y = 0; q_z = 0;
        ref_valid = 0; ref_x = 0; ref_y = 0; ref_z = 0; ref_id = 0;
        bdu_terminate = 0; bdu_done = 0;
        tick(2);
        chk("rst_valid", valid, 0);
        chk("rst_q_bit", q_bit, 0);
        chk("rst_r_bit", r_bit, 0);
        chk("rst_code", code, 0);
        chk("rst_b", b, 0);
        chk("rst_retire", retire, 0);
        chk("rst_kept", retire_kept, 0);
        chk("rst_id", retire_id, 0);
        chk("rst_q_ready", q_ready, 1);
        chk("rst_ref_ready", ref_ready, 0);
        rst_n = 1;
        chk_en = 1;
        tick(1);

        // ref_valid held in IDLE must not be taken
        ref_valid = 1; ref_id = 77;
        tick(3);
        ref_valid = 0;
        chk("idle_no_stream", valid, 0);

        // query load, then overwrite from READY
        load_q(1, 1, 1);
        load_q(5, 7, 9);
        push_ref(4, 7, 10, 3);
        chk("t1_valid", valid, 1);
        chk("t1_b", b, 1);
        chk("t1_code", code, 1);
        tick(93);
        chk("b32x_b", b, 32);
        chk("b32x_code", code, 1);
        chk("b32x_q", q_bit, 1);
        chk("b32x_r", r_bit, 0);
        tick(1);
        chk("b32y_q", q_bit, 1);
        chk("b32y_r", r_bit, 1);
        tick(1);
        chk("b32z_code", code, 3);
        chk("b32z_q", q_bit, 1);
        chk("b32z_r", r_bit, 0);
        tick(1);
        chk("drain_valid", valid, 0);
        tick(1);
        chk("done_retire", retire, 1);
        chk("done_kept", retire_kept, 1);
        chk("done_id", retire_id, 3);
        tick(1);

        // terminate at the 10th bit
        term_k = 9; term_id = 5;
        push_ref(32'h8000_0001, 2, 3, 5);
        if (PF) begin
            push_ref(32'hffff_ffff, 0, 32'h1234_5678, 6);
            tick(8);
        end else begin
            tick(9);
        end
        t_term = cyc;
        chk("term_b", b, 4);
        chk("term_code", code, 1);
        tick(1);
        chk("term_retire", retire, 1);
        chk("term_kept", retire_kept, 0);
        chk("term_id", retire_id, 5);
        if (PF) begin
            chk("pf_next_valid", valid, 1);
            chk("pf_next_b", b, 1);
            chk("pf_next_gap", cyc - t_term, 1);
        end else begin
            chk("after_term_valid", valid, 0);
            push_ref(32'hffff_ffff, 0, 32'h1234_5678, 6);
            chk("next_first_gap", cyc - t_term, 2);
        end
        wait_retire(1, 6);
        term_k = -1;

        // threshold-0 BDU: one bit per ref
        thr0 = 1; cnt_en = 1;
        for (int i = 0; i < 4; i++) begin
            push_ref(32'(i * 3 + 1), 32'(i), 32'hdead_beef, 16'(20 + i));
            wait_retire(0, 16'(20 + i));
        end
        cnt_en = 0; thr0 = 0;
        chk("thr0_bits", nbits, 4);
        chk("thr0_retires", nret, 4);
        chk("thr0_kept", nkept, 0);

        // simultaneous done and terminate in DRAIN
        both_mode = 1;
        push_ref(9, 9, 9, 9);
        wait_retire(0, 9);
        both_mode = 0;

        // asynchronous reset mid-stream at b=17
        push_ref(32'h0f0f_0f0f, 32'hf0f0_f0f0, 32'h5555_aaaa, 11);
        tick(48);
        chk("pre_rst_b", b, 17);
        #2 rst_n = 0;
        #1;
        chk("arst_valid", valid, 0);
        chk("arst_code", code, 0);
        chk("arst_b", b, 0);
        chk("arst_retire", retire, 0);
        chk("arst_q_ready", q_ready, 1);
        chk("arst_ref_ready", ref_ready, 0);
        tick(1);
        rst_n = 1;
        tick(3);
        chk("post_rst_retire", retire, 0);

        // back-to-back refs ids 1,2
        load_q(32'h7fff_ffff, 32'h8000_0000, 32'h0000_ffff);
        push_ref(32'h1357_9bdf, 32'h2468_ace0, 32'hffff_0000, 1);
        f1 = cyc;
        push_ref(32'haaaa_5555, 32'h0000_0001, 32'h8000_0000, 2);
        found = 0;
        f2 = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (valid && b == 1 && code == 1 && cyc > f1) begin
                found = 1;
                f2 = cyc;
            end
        end
        chk("b2b_found", found, 1);
        chk("b2b_gap", f2 - f1, PF ? 97 : 98);
        tick(1);
        wait_retire(1, 2);
        tick(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bdu_bit_streamer.md
# bdu_bit_streamer

Feeds one bit-serial distance unit (BDU) from parallel point storage. It holds the current query point and serializes one accepted reference point at a time, MSB first, interleaved x,y,z, driving the BDU's `valid`, `q_bit`, `r_bit`, `code` and `b` inputs. It watches the BDU's `terminate` and `done` outputs to abandon or retire each reference, then signals the retirement upstream. It sits between the reference-point fetch logic and one BDU lane.

## Interface
- `B`, 32: coordinate bit width; must match the BDU.
- `ID_W`, 16: width of the reference-point tag.

- `clk`  in  1: clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `q_load`  in  1: load a new query point; accepted only when `q_ready`.
- `q_ready`  out  1: high in IDLE and READY.
- `q_x`, `q_y`, `q_z`  in  B each: query coordinates.
- `ref_valid`  in  1: upstream handshake.
- `ref_ready`  out  1: upstream handshake.
- `ref_x`, `ref_y`, `ref_z`  in  B each: reference coordinates.
- `ref_id`  in  ID_W: reference tag.
- `bdu_terminate`  in  1: BDU `terminate`.
- `bdu_done`  in  1: BDU `done`.
- `valid`  out  1: bit valid to BDU.
- `q_bit`, `r_bit`  out  1 each: current query and reference bit.
- `code`  out  2: 01 = x, 10 = y, 11 = z; 00 when idle.
- `b`  out  $clog2(B+1): bit index, 1 = MSB, B = LSB.
- `retire`  out  1: one-cycle pulse when a reference leaves the BDU.
- `retire_kept`  out  1: with `retire`; 1 = completed (kNN candidate), 0 = terminated.
- `retire_id`  out  ID_W: tag of the retired reference.

## Operation
- States:
  - IDLE: no query held.
  - READY: query held, no reference active.
  - STREAM: emitting bits.
  - DRAIN: all 3B bits sent; waiting for the BDU verdict.
- IDLE → READY on `q_load`. READY also accepts `q_load`, which overwrites the query.
- READY: `ref_ready`=1. On handshake, latch the point and id, set `b`=1 and `code`=01, and go to STREAM.
- STREAM: `valid`=1 every cycle.
  - `q_bit`/`r_bit` = bit [B-b] of the selected dimension of the query/reference.
  - `code` cycles 01→10→11. After 11, `b` increments.
  - After the cycle emitting `b`=B, `code`=11, go to DRAIN.
- DRAIN: `valid`=0. Leave on `bdu_done` or `bdu_terminate`.
- `bdu_terminate` in STREAM: the bit driven that cycle is treated as discarded. Leave STREAM at the next edge.
- Leaving STREAM or DRAIN: the next state is READY, or STREAM if a prefetched point exists (see Configuration).
- Simultaneous `bdu_done` and `bdu_terminate`: terminate wins, so `retire_kept`=0.
- `bdu_terminate`/`bdu_done` are ignored in IDLE and READY.
- `ref_valid` held while in IDLE: not accepted. `ref_ready`=0 in IDLE.
- Reset mid-stream: everything clears and the in-flight reference is dropped without `retire`.

## Timing
- Reset values:
  - state IDLE
  - `valid`, `q_bit`, `r_bit`, `retire`, `retire_kept` = 0
  - `code` = 00, `b` = 0, `retire_id` = 0
  - `q_ready` = 1, `ref_ready` = 0
- All BDU-facing outputs are registered.
- Handshake at cycle t: first bit (`b`=1, x) at t+1; last bit (`b`=B, z) at t+3B. DRAIN begins t+3B+1, the cycle the BDU raises `done`.
- `retire`/`retire_kept`/`retire_id` are registered: asserted the cycle after `bdu_done`/`bdu_terminate` is sampled.
- Throughput without prefetch: one reference per 3B+2 cycles for a completed point (READY bubble). Terminated point: exit cycle + 1 bubble.

## Configuration
- `BDU_STREAM_PREFETCH_EN` defined:
  - Adds a one-entry prefetch buffer. `ref_ready` = buffer empty and state ≠ IDLE, so points are accepted during STREAM/DRAIN.
  - On exit from STREAM/DRAIN with the buffer full, the next cycle emits `b`=1, x of the buffered point (no READY bubble). A completed point then takes 3B+1 cycles.
  - `q_load` is also refused while the buffer is full.
- Undefined: no buffer; `ref_ready` only in READY.

## Structure
- Shared package `knn_pkg`:
  - `B`
  - `CODE_X`/`CODE_Y`/`CODE_Z` = 2'b01/2'b10/2'b11
  - `point_t` (x, y, z, each B bits)
  - `ref_tag_t` (ID_W)
- One sub-module: `point_shreg`. It holds a `point_t` and returns the bit for a given `b`/`code`. It is instantiated for the query, the active reference, and (when enabled) the prefetch buffer.

## Test plan
- Reset, load query (5,7,9), push ref (4,7,10) with id 3, BDU model never terminates:
  - Bits appear at t+1..t+96. At `b`=32 the triples are x(1,0), y(1,1), z(1,0).
  - `done` arrives at t+97; `retire`=1, `retire_kept`=1, `retire_id`=3 at t+98.
- `bdu_terminate` forced at the 10th bit (`b`=4, x):
  - `valid`=0 the next cycle.
  - `retire_kept`=0 one cycle after terminate.
  - Next ref's first bit 2 cycles after terminate (1 with prefetch).
- Threshold 0 model (terminate every STREAM cycle), 4 refs: each emits exactly one bit and retires with kept=0.
- Simultaneous `done` and `terminate` in DRAIN: `retire_kept`=0.
- Assert `rst_n`=0 mid-stream at `b`=17: outputs go to reset values asynchronously; no `retire`.
- `BDU_STREAM_PREFETCH_EN`, back-to-back refs ids 1,2: id 2 accepted during STREAM; first bit of id 2 exactly 97 cycles after first bit of id 1.
